// File: rtl/unidade_controle.sv
// Stack-machine control unit: fetch/decode/execute/write-back FSM driving an
// external ALU and a synchronous instruction ROM, with an internal 8-deep stack.
module unidade_controle (
    input  logic        clock,
    input  logic        reset,
    output logic [7:0]  pc,
    input  logic [15:0] instrucao,
    output logic [4:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [31:0] alu_res,
    input  logic        alu_flag,
    output logic [15:0] topo,
    output logic [3:0]  sp,
    output logic        halt,
    output logic        erro
);

    typedef enum logic [2:0] {
        BUSCA, DECODIFICA, EXECUTA, ESCREVE, PARADO, ERRO
    } state_t;

    typedef enum logic [4:0] {
        OP_NOP   = 5'b00000, OP_PUSH  = 5'b00010, OP_POP   = 5'b00011,
        OP_ADD   = 5'b00100, OP_SUB   = 5'b00101, OP_MUL   = 5'b00110,
        OP_DIV   = 5'b00111, OP_AND   = 5'b01000, OP_NAND  = 5'b01001,
        OP_OR    = 5'b01010, OP_XOR   = 5'b01011, OP_CMP   = 5'b01100,
        OP_NOT   = 5'b01101, OP_GOTO  = 5'b01110, OP_IF_EQ = 5'b01111,
        OP_IF_GT = 5'b10000, OP_IF_LT = 5'b10001, OP_IF_GE = 5'b10010,
        OP_IF_LE = 5'b10011, OP_HALT  = 5'b11111
    } opcode_t;

    function automatic logic is_binary(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_CMP);
    endfunction

    function automatic logic is_branch(input logic [4:0] op);
        return (op >= OP_IF_EQ) && (op <= OP_IF_LE);
    endfunction

    state_t      state;
    logic [15:0] stack [8];
    logic [4:0]  op_q;
    logic [7:0]  target_q;
    logic [15:0] res_q;
    logic        flag_q;

    logic [4:0]  op_in;
    logic [3:0]  need;
    logic        legal;
    logic [2:0]  idx_top;
    logic [2:0]  idx_sec;
    logic        unused_res_hi;

    assign unused_res_hi = ^alu_res[31:16];

    always_comb begin
        op_in   = instrucao[15:11];
        idx_top = 3'(sp - 4'd1);
        idx_sec = 3'(sp - 4'd2);
        legal   = 1'b1;
        need    = 4'd0;
        case (op_in)
            OP_NOP, OP_PUSH, OP_GOTO, OP_HALT: need = 4'd0;
            OP_POP, OP_NOT, OP_IF_EQ, OP_IF_GT,
            OP_IF_LT, OP_IF_GE, OP_IF_LE:      need = 4'd1;
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND,
            OP_NAND, OP_OR, OP_XOR, OP_CMP:    need = 4'd2;
            default:                           legal = 1'b0;
        endcase
    end

    // ALU operands are registered on the DECODIFICA->EXECUTA edge so they are
    // valid for exactly the EXECUTA cycle; the ALU result is captured there too.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= BUSCA;
            pc       <= '0;
            sp       <= '0;
            topo     <= '0;
            halt     <= 1'b0;
            erro     <= 1'b0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            op_q     <= '0;
            target_q <= '0;
            res_q    <= '0;
            flag_q   <= 1'b0;
        end else begin
            case (state)
                BUSCA: state <= DECODIFICA;
                DECODIFICA: begin
                    op_q     <= op_in;
                    target_q <= instrucao[7:0];
                    if (!legal || need > sp || (op_in == OP_PUSH && sp == 4'd8)) begin
                        state <= ERRO;
                        erro  <= 1'b1;
                    end else if (op_in == OP_HALT) begin
                        state <= PARADO;
                        halt  <= 1'b1;
                    end else begin
                        state  <= EXECUTA;
                        alu_op <= op_in;
                        alu_a  <= '0;
                        alu_b  <= '0;
                        if (op_in == OP_PUSH)
                            alu_a <= {5'b0, instrucao[10:0]};
                        else if (op_in == OP_NOT || is_branch(op_in))
                            alu_a <= topo;
                        else if (is_binary(op_in)) begin
                            alu_a <= stack[idx_sec];
                            alu_b <= topo;
                        end
                    end
                end
                EXECUTA: begin
                    res_q  <= alu_res[15:0];
                    flag_q <= alu_flag;
                    alu_op <= '0;
                    alu_a  <= '0;
                    alu_b  <= '0;
                    state  <= ESCREVE;
                end
                ESCREVE: begin
                    state <= BUSCA;
                    if (op_q == OP_GOTO || (is_branch(op_q) && flag_q))
                        pc <= target_q;
                    else
                        pc <= pc + 8'd1;
                    if (is_binary(op_q)) begin
                        stack[idx_sec] <= res_q;
                        sp             <= sp - 4'd1;
                        topo           <= res_q;
                    end else if (op_q == OP_NOT) begin
                        stack[idx_top] <= res_q;
                        topo           <= res_q;
                    end else if (op_q == OP_PUSH) begin
                        stack[sp[2:0]] <= res_q;
                        sp             <= sp + 4'd1;
                        topo           <= res_q;
                    end else if (op_q == OP_POP || is_branch(op_q)) begin
                        sp   <= sp - 4'd1;
                        topo <= (sp >= 4'd2) ? stack[idx_sec] : '0;
                    end
                end
                PARADO: state <= PARADO;
                ERRO:   state <= ERRO;
                default: state <= ERRO;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a behavioural ROM and ALU around it.
module tb_unidade_controle;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pc;
    logic [15:0] instrucao = '0;
    logic [4:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic [31:0] alu_res;
    logic        alu_flag;
    logic [15:0] topo;
    logic [3:0]  sp;
    logic        halt, erro;

    logic [15:0] rom [256];
    int compared = 0;
    int mismatched = 0;

    unidade_controle dut (
        .clock(clock), .reset(reset), .pc(pc), .instrucao(instrucao),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .alu_flag(alu_flag), .topo(topo), .sp(sp), .halt(halt), .erro(erro)
    );

    always #5 clock = ~clock;

    always @(posedge clock) instrucao <= rom[pc];

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        case (alu_op)
            5'b00010: alu_res = {16'h0, alu_a};
            5'b00100: alu_res = {16'h0, alu_a + alu_b};
            5'b00101: alu_res = {16'h0, alu_a - alu_b};
            5'b00110: alu_res = 32'(alu_a) * 32'(alu_b);
            5'b00111: alu_res = (alu_b != 0) ? 32'(alu_a / alu_b) : '0;
            5'b01000: alu_res = {16'h0, alu_a & alu_b};
            5'b01001: alu_res = {16'h0, ~(alu_a & alu_b)};
            5'b01010: alu_res = {16'h0, alu_a | alu_b};
            5'b01011: alu_res = {16'h0, alu_a ^ alu_b};
            5'b01100: alu_res = (alu_a < alu_b) ? 32'h0000FFFF :
                                (alu_a == alu_b) ? 32'h0 : 32'h1;
            5'b01101: alu_res = {16'h0, ~alu_a};
            5'b01111: alu_flag = (alu_a == 16'h0);
            5'b10000: alu_flag = ($signed(alu_a) > 0);
            5'b10001: alu_flag = ($signed(alu_a) < 0);
            5'b10010: alu_flag = ($signed(alu_a) >= 0);
            5'b10011: alu_flag = ($signed(alu_a) <= 0);
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF800;
    endtask

    task automatic restart();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        clear_rom();
        step(2);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_sp", 32'(sp), 0);
        chk("rst_topo", 32'(topo), 0);
        chk("rst_flags", {30'h0, halt, erro}, 0);
        chk("rst_alu", {alu_op, alu_a, alu_b}, 0);

        // Push 5; Push 3; Add; Halt
        rom[0] = 16'h1005; rom[1] = 16'h1003; rom[2] = 16'h2000;
        restart();
        step(8);
        chk("add_pre_sp", 32'(sp), 2);
        chk("add_pre_topo", 32'(topo), 3);
        step(2);
        chk("add_exec_op", 32'(alu_op), 5'b00100);
        chk("add_exec_a", 32'(alu_a), 5);
        chk("add_exec_b", 32'(alu_b), 3);
        step(6);
        chk("add_topo", 32'(topo), 8);
        chk("add_sp", 32'(sp), 1);
        chk("add_halt", 32'(halt), 1);
        chk("add_pc", 32'(pc), 3);
        chk("add_alu_idle", 32'(alu_op), 0);
        step(8);
        chk("halt_frozen_pc", 32'(pc), 3);

        // Push 2; Push 7; Cmp
        clear_rom();
        rom[0] = 16'h1002; rom[1] = 16'h1007; rom[2] = 16'h6000;
        restart();
        step(12);
        chk("cmp_topo", 32'(topo), 16'hFFFF);
        chk("cmp_sp", 32'(sp), 1);

        // Push 7; Push 2; Sub
        rom[0] = 16'h1007; rom[1] = 16'h1002; rom[2] = 16'h2800;
        restart();
        step(12);
        chk("sub_topo", 32'(topo), 5);
        chk("sub_sp", 32'(sp), 1);

        // Push 9; Push 4; Pop; Not; Halt
        rom[0] = 16'h1009; rom[1] = 16'h1004; rom[2] = 16'h1800; rom[3] = 16'h6800;
        restart();
        step(12);
        chk("pop_topo", 32'(topo), 9);
        chk("pop_sp", 32'(sp), 1);
        step(6);
        chk("not_topo", 32'(topo), 16'hFFF6);
        chk("not_halt", 32'(halt), 1);

        // Push 0; If_eq 10 (taken)
        clear_rom();
        rom[0] = 16'h1000; rom[1] = 16'h780A;
        restart();
        step(8);
        chk("ifeq_t_pc", 32'(pc), 10);
        chk("ifeq_t_sp", 32'(sp), 0);
        chk("ifeq_t_topo", 32'(topo), 0);

        // Push 1; If_eq 10 (not taken)
        rom[0] = 16'h1001;
        restart();
        step(8);
        chk("ifeq_nt_pc", 32'(pc), 2);
        chk("ifeq_nt_sp", 32'(sp), 0);

        // Add with empty stack
        rom[0] = 16'h2000;
        restart();
        step(2);
        chk("under_erro", 32'(erro), 1);
        chk("under_sp", 32'(sp), 0);
        step(10);
        chk("under_sticky", {pc, 3'b0, halt, sp, 15'h0, erro}, 1);

        // Illegal opcode 00001
        rom[0] = 16'h0800;
        restart();
        step(2);
        chk("illegal_erro", 32'(erro), 1);

        // Nine pushes
        clear_rom();
        for (int i = 0; i < 9; i++) rom[i] = 16'h1001 + 16'(i);
        restart();
        step(32);
        chk("full_sp", 32'(sp), 8);
        chk("full_topo", 32'(topo), 8);
        chk("full_erro0", 32'(erro), 0);
        step(2);
        chk("over_erro", 32'(erro), 1);
        chk("over_sp", 32'(sp), 8);
        chk("over_pc", 32'(pc), 8);

        // Reset during EXECUTA of Add, then re-run
        clear_rom();
        rom[0] = 16'h1005; rom[1] = 16'h1003; rom[2] = 16'h2000;
        restart();
        step(10);
        chk("midrst_exec_op", 32'(alu_op), 5'b00100);
        reset = 1'b1;
        step(1);
        chk("midrst_pc", 32'(pc), 0);
        chk("midrst_sp", 32'(sp), 0);
        chk("midrst_topo", 32'(topo), 0);
        chk("midrst_alu", {alu_op, alu_a, alu_b}, 0);
        reset = 1'b0;
        step(16);
        chk("rerun_topo", 32'(topo), 8);
        chk("rerun_state", {pc, 7'h0, halt, sp}, {8'd3, 7'h0, 1'b1, 4'd1});

        // Goto 255; Nop at 255 wraps to 0
        clear_rom();
        rom[0] = 16'h70FF; rom[255] = 16'h0000;
        restart();
        step(4);
        chk("goto_pc", 32'(pc), 255);
        step(4);
        chk("wrap_pc", 32'(pc), 0);
        chk("wrap_sp", 32'(sp), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high. The ports are named clock and reset.
REQ-002 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port pc, output, 8 bits: instruction address to the synchronous ROM (1-cycle read latency).
REQ-005 The block SHALL have port instrucao, input, 16 bits: ROM data; [15:11] opcode, [10:0] immediate.
REQ-006 The block SHALL have port alu_op, output, 5 bits: opcode driven to the ALU.
REQ-007 The block SHALL have ports alu_a and alu_b, output, 16 bits each: ALU operando1 and operando2.
REQ-008 The block SHALL have port alu_res, input, 32 bits: ALU resultado; only [15:0] is used.
REQ-009 The block SHALL have port alu_flag, input, 1 bit: ALU data_uc (branch-taken condition).
REQ-010 The block SHALL have port topo, output, 16 bits: top of stack, or 0 when the stack is empty.
REQ-011 The block SHALL have port sp, output, 4 bits: stack occupancy, 0..8.
REQ-012 The block SHALL have ports halt and erro, output, 1 bit each: halted flag and sticky fault flag.

Function
REQ-013 Opcode set SHALL be:
- Nop 00000, Push 00010, Pop 00011
- Add 00100, Sub 00101, Mul 00110, Div 00111
- And 01000, Nand 01001, Or 01010, Xor 01011, Cmp 01100
- Not 01101, Goto 01110
- If_eq 01111, If_gt 10000, If_lt 10001, If_ge 10010, If_le 10011
- Halt 11111
REQ-014 All other opcodes SHALL enter ERRO.
REQ-015 The state machine SHALL have states BUSCA, DECODIFICA, EXECUTA, ESCREVE, PARADO and ERRO.
- Transitions: BUSCA->DECODIFICA->EXECUTA->ESCREVE->BUSCA.
- Every instruction takes exactly 4 cycles.
REQ-016 BUSCA SHALL present pc to the ROM. DECODIFICA SHALL latch instrucao and check operand count and stack space.
REQ-017 The stack SHALL be internal: 8 entries x 16 bits, LIFO, indexed by sp.
REQ-018 In EXECUTA only, alu_op, alu_a and alu_b SHALL be driven from the latched instruction. In all other states they SHALL be 0.
REQ-019 Binary ops (Add..Cmp) SHALL require sp>=2.
- alu_a = second entry, alu_b = top.
- In ESCREVE: pop 2, push alu_res[15:0]; net sp-1.
REQ-020 Not SHALL require sp>=1: alu_a = top, alu_b = 0; ESCREVE replaces the top with alu_res[15:0].
REQ-021 Push SHALL require sp<=7: alu_a = zero-extended immediate; ESCREVE pushes alu_res[15:0].
REQ-022 Pop SHALL require sp>=1: discard the top; the ALU is not used.
REQ-023 Branches If_xx SHALL require sp>=1.
- alu_a = top; the top is popped in ESCREVE.
- alu_flag is sampled in EXECUTA.
- Taken: pc <= immediate[7:0]. Not taken: pc <= pc+1.
REQ-024 Goto SHALL set pc <= immediate[7:0] unconditionally. Nop SHALL set pc <= pc+1 only.
REQ-025 Non-branch instructions SHALL set pc <= pc+1 in ESCREVE, wrapping 255->0.
REQ-026 Halt SHALL go DECODIFICA->PARADO.
- halt=1; pc, sp and stack are frozen.
- The block stays in PARADO until reset.
REQ-027 Underflow (operands > sp), overflow (Push at sp=8) or an illegal opcode, detected in DECODIFICA, SHALL go to ERRO.
- erro=1; pc, sp and stack are unchanged.
- The block stays in ERRO until reset.
REQ-028 Div by zero SHALL NOT be trapped; the ALU result is pushed as-is.
REQ-029 topo and sp SHALL be registered and update in the same cycle the stack is written.

Reset
REQ-030 When reset=1 at a clock edge, in any state including mid-instruction, the block SHALL set:
- state BUSCA, pc=0, sp=0, topo=0, halt=0, erro=0
- alu_op=0, alu_a=0, alu_b=0
REQ-031 Stack contents need not be cleared on reset; with sp=0 they are unreachable.
REQ-032 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-033 Push 5; Push 3; Add; Halt -> after 16 cycles: topo=8, sp=1, halt=1, pc=3; alu_op=00100 with alu_a=5, alu_b=3 during Add EXECUTA.
REQ-034 Push 2; Push 7; Cmp -> topo=16'hFFFF, sp=1. Push 7; Push 2; Sub -> topo=5, sp=1.
REQ-035 Push 0; If_eq imm=10 -> pc=10, sp=0. Push 1; If_eq imm=10 at pc=1 -> pc=2.
REQ-036 Add as the first instruction (sp=0) -> erro=1, sp=0, pc=0, state ERRO until reset. Nine consecutive Push -> erro=1, sp=8.
REQ-037 Assert reset during EXECUTA of Add -> next cycle pc=0, sp=0, topo=0, alu_op=0; the program re-runs from address 0.
REQ-038 Goto 255 then Nop at 255 -> pc wraps to 0.
